// File: rtl/access_pkg.sv
// Shared types and constants for the door-lock code sender.
package access_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_RESP = 3'd2,
        OPEN      = 3'd3,
        LOCKOUT   = 3'd4
    } state_e;

    localparam int CODE_W   = 4;
    localparam int CODE_MIN = 4;
    localparam int CODE_MAX = 11;
    localparam int TIMER_W  = 8;
    localparam int FAIL_W   = 3;
    localparam int STAT_W   = 8;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        sat_inc = (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/access_code_sender_cycle_timer.sv
// Up-counter with synchronous clear that stops at a runtime terminal value.
module cycle_timer
    import access_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               done
);

    logic [TIMER_W-1:0] count_d;
    logic [TIMER_W-1:0] count_q;

    // Next count: clear wins, otherwise count up and hold at the limit so it never wraps.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {TIMER_W{1'b0}};
        end else if (enable && (count_q != limit)) begin
            count_d = count_q + TIMER_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {TIMER_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign done = enable && (count_q == limit);

endmodule

// File: rtl/access_code_sender.sv
// Keypad-to-lock code sender with denial counting and lockout.
// Optional ACCESS_STATS_EN adds saturating grant/deny counters.
module access_code_sender
    import access_pkg::*;
#(
    parameter int FAIL_LIMIT     = 3,
    parameter int RESP_TIMEOUT   = 4,
    parameter int LOCKOUT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [CODE_W-1:0] key_code,
    input  logic              key_submit,
    input  logic              open_access_door,
    output logic              validate_code,
    output logic [CODE_W-1:0] access_code,
    output logic              busy,
    output logic              locked_out,
    output logic [FAIL_W-1:0] fail_count
`ifdef ACCESS_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_count,
    output logic [STAT_W-1:0] deny_count
`endif
);

    localparam logic [FAIL_W-1:0]  FAIL_LIMIT_C = FAIL_W'(FAIL_LIMIT);
    localparam logic [TIMER_W-1:0] RESP_LAST    = TIMER_W'(RESP_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCKOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                has_code_q, has_code_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [FAIL_W-1:0]   fail_inc_s;
    logic                timer_clear_s;
    logic                timer_en_s;
    logic [TIMER_W-1:0]  timer_limit_s;
    logic                timer_done_s;

    cycle_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear_s),
        .enable (timer_en_s),
        .limit  (timer_limit_s),
        .done   (timer_done_s)
    );

    // Next-state, code capture and denial bookkeeping.
    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        has_code_d    = has_code_q;
        fail_d        = fail_q;
        timer_en_s    = 1'b0;
        timer_limit_s = RESP_LAST;
        fail_inc_s    = (fail_q >= FAIL_LIMIT_C) ? FAIL_LIMIT_C : fail_q + FAIL_W'(1);

        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    code_d     = key_code;
                    has_code_d = 1'b1;
                end else begin
                    code_d     = code_q;
                end
                // A digit arriving with submit counts as held.
                if (key_submit && (has_code_q || key_valid)) begin
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                timer_en_s    = 1'b1;
                timer_limit_s = RESP_LAST;
                if (open_access_door) begin
                    state_d    = OPEN;
                    fail_d     = {FAIL_W{1'b0}};
                    has_code_d = 1'b0;
                end else if (timer_done_s) begin
                    fail_d     = fail_inc_s;
                    has_code_d = 1'b0;
                    state_d    = (fail_inc_s == FAIL_LIMIT_C) ? LOCKOUT : IDLE;
                end else begin
                    state_d = WAIT_RESP;
                end
            end
            OPEN: begin
                if (!open_access_door) begin
                    state_d = IDLE;
                end else begin
                    state_d = OPEN;
                end
            end
            LOCKOUT: begin
                timer_en_s    = 1'b1;
                timer_limit_s = LOCK_LAST;
                if (timer_done_s) begin
                    state_d = IDLE;
                    fail_d  = {FAIL_W{1'b0}};
                end else begin
                    state_d = LOCKOUT;
                end
            end
            default: begin
                state_d    = IDLE;
                has_code_d = 1'b0;
            end
        endcase

        timer_clear_s = (state_d != state_q);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= {CODE_W{1'b0}};
            has_code_q <= 1'b0;
            fail_q     <= {FAIL_W{1'b0}};
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            has_code_q <= has_code_d;
            fail_q     <= fail_d;
        end
    end

    assign validate_code = (state_q == SEND);
    assign busy          = (state_q != IDLE);
    assign locked_out    = (state_q == LOCKOUT);
    assign access_code   = code_q;
    assign fail_count    = fail_q;

`ifdef ACCESS_STATS_EN
    logic [STAT_W-1:0] grant_q, grant_d;
    logic [STAT_W-1:0] deny_q, deny_d;
    logic              grant_ev_s;
    logic              deny_ev_s;

    // Attempt outcomes, counted saturating.
    always_comb begin
        grant_ev_s = (state_q == WAIT_RESP) && open_access_door;
        deny_ev_s  = (state_q == WAIT_RESP) && !open_access_door && timer_done_s;
        grant_d    = grant_ev_s ? sat_inc(grant_q) : grant_q;
        deny_d     = deny_ev_s  ? sat_inc(deny_q)  : deny_q;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= {STAT_W{1'b0}};
            deny_q  <= {STAT_W{1'b0}};
        end else begin
            grant_q <= grant_d;
            deny_q  <= deny_d;
        end
    end

    assign grant_count = grant_q;
    assign deny_count  = deny_q;
`endif

endmodule

// File: tb/tb_access_code_sender.sv
// Directed bench for access_code_sender with a simple lock model attached.
module tb_access_code_sender;
    import access_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_submit = 1'b0;
    logic       door;
    logic       validate_code;
    logic [3:0] access_code;
    logic       busy;
    logic       locked_out;
    logic [2:0] fail_count;
`ifdef ACCESS_STATS_EN
    logic [7:0] grant_count;
    logic [7:0] deny_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int exp_grant = 0;
    int exp_deny = 0;
    int lock_cycles;

    logic lock_pend;
    int   door_cnt;

    always #5 clk = ~clk;

    access_code_sender dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .key_submit       (key_submit),
        .open_access_door (door),
        .validate_code    (validate_code),
        .access_code      (access_code),
        .busy             (busy),
        .locked_out       (locked_out),
        .fail_count       (fail_count)
`ifdef ACCESS_STATS_EN
        ,
        .grant_count      (grant_count),
        .deny_count       (deny_count)
`endif
    );

    // Lock model: validate seen at e1, door opens at e2, held for 6 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_pend <= 1'b0;
            door      <= 1'b0;
            door_cnt  <= 0;
        end else begin
            lock_pend <= validate_code && (access_code >= 4'(CODE_MIN)) && (access_code <= 4'(CODE_MAX));
            if (lock_pend) begin
                door     <= 1'b1;
                door_cnt <= 6;
            end else if (door) begin
                if (door_cnt == 1) door <= 1'b0;
                door_cnt <= door_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_code  = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic submit();
        key_submit = 1'b1;
        tick();
        key_submit = 1'b0;
    endtask

    task automatic check_stats();
`ifdef ACCESS_STATS_EN
        chk("grant_cnt", 32'(grant_count), 32'(exp_grant));
        chk("deny_cnt", 32'(deny_count), 32'(exp_deny));
`endif
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && busy; i++) tick();
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Called right after the edge that sampled submit.
    task automatic grant_tail(input logic [3:0] d);
        chk("grant_vld", 32'(validate_code), 32'd1);
        chk("grant_code", 32'(access_code), 32'(d));
        tick();
        chk("grant_vld_1cyc", 32'(validate_code), 32'd0);
        tick();
        tick();
        chk("grant_open", 32'(dut.state_q), 32'(OPEN));
        chk("grant_fail0", 32'(fail_count), 32'd0);
        exp_grant++;
        check_stats();
        wait_idle("grant_idle");
    endtask

    task automatic grant_attempt(input logic [3:0] d);
        press(d);
        submit();
        grant_tail(d);
    endtask

    task automatic deny_attempt(input logic [3:0] d, input logic [2:0] exp_fail);
        logic exp_lock;
        exp_lock = (exp_fail == 3'd3);
        press(d);
        submit();
        chk("deny_vld", 32'(validate_code), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("deny_busy", 32'(busy), 32'd1);
            chk("deny_code", 32'(access_code), 32'(d));
            chk("deny_vld0", 32'(validate_code), 32'd0);
        end
        tick();
        chk("deny_fail", 32'(fail_count), 32'(exp_fail));
        chk("deny_lock", 32'(locked_out), 32'(exp_lock));
        chk("deny_end_busy", 32'(busy), 32'(exp_lock));
        exp_deny++;
        check_stats();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 32'(validate_code), 32'd0);
        chk("rst_code", 32'(access_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lock", 32'(locked_out), 32'd0);
        chk("rst_fail", 32'(fail_count), 32'd0);
        check_stats();
        #2 rst_n = 1'b1;
        tick();

        // Grant path
        grant_attempt(4'd9);

        // Denial
        deny_attempt(4'd2, 3'd1);

        // Recovery after two denials
        deny_attempt(4'd14, 3'd2);
        grant_attempt(4'd4);
        deny_attempt(4'd12, 3'd1);
        grant_attempt(4'd10);

        // Lockout after three consecutive denials
        deny_attempt(4'd0, 3'd1);
        deny_attempt(4'd15, 3'd2);
        deny_attempt(4'd3, 3'd3);
        lock_cycles = 1;
        for (int i = 0; i < 100; i++) begin
            key_valid  = 1'b1;
            key_code   = 4'd9;
            key_submit = 1'b1;
            tick();
            if (locked_out) lock_cycles++;
            else break;
        end
        key_valid  = 1'b0;
        key_submit = 1'b0;
        chk("lock_len", 32'(lock_cycles), 32'd32);
        chk("lock_fail_clr", 32'(fail_count), 32'd0);
        chk("lock_idle", 32'(busy), 32'd0);
        chk("lock_keys_ignored", 32'(access_code), 32'd3);

        // Submit with no held digit
        submit();
        chk("nodigit_vld", 32'(validate_code), 32'd0);
        chk("nodigit_busy", 32'(busy), 32'd0);

        // Digit and submit together
        key_valid  = 1'b1;
        key_code   = 4'd11;
        key_submit = 1'b1;
        tick();
        key_valid  = 1'b0;
        key_submit = 1'b0;
        grant_tail(4'd11);

        // Last digit wins
        press(4'd5);
        press(4'd7);
        submit();
        grant_tail(4'd7);

        // Reset during WAIT_RESP with two denials on record
        deny_attempt(4'd2, 3'd1);
        deny_attempt(4'd13, 3'd2);
        press(4'd1);
        submit();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(validate_code), 32'd0);
        chk("arst_code", 32'(access_code), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_lock", 32'(locked_out), 32'd0);
        chk("arst_fail", 32'(fail_count), 32'd0);
        exp_grant = 0;
        exp_deny  = 0;
        check_stats();
        #1 rst_n = 1'b1;
        tick();
        deny_attempt(4'd0, 3'd1);

        // Reset while validate is high drops it without a clock edge
        press(4'd6);
        submit();
        chk("send_vld", 32'(validate_code), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("send_arst_vld", 32'(validate_code), 32'd0);
        chk("send_arst_fail", 32'(fail_count), 32'd0);
        #1 rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/access_code_sender.md
Name: access_code_sender

Overview:
- Initiator side of the door-lock code interface.
- Collects keypad digits, drives the lock's `validate_code` pulse and `access_code` bus, then watches `open_access_door` to classify each attempt as granted or denied.
- Counts consecutive denials and forces a keypad lockout after `FAIL_LIMIT` failures.
- Sits between the keypad scanner and the door-lock FSM.

Parameters:
- FAIL_LIMIT, 3, consecutive denials that trigger lockout; legal range 1..7.
- RESP_TIMEOUT, 4, cycles spent in WAIT_RESP without door open before the attempt is declared denied; minimum 3.
- LOCKOUT_CYCLES, 32, cycles spent in LOCKOUT; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- key_valid  in  1  one-cycle strobe; key_code is a digit.
- key_code  in  4  digit value 0..15.
- key_submit  in  1  one-cycle strobe; send the held code.
- open_access_door  in  1  door-unlocked status from the lock.
- validate_code  out  1  one-cycle pulse to the lock.
- access_code  out  4  code presented to the lock; stable from SEND through the end of WAIT_RESP.
- busy  out  1  high in every state except IDLE.
- locked_out  out  1  high in LOCKOUT only.
- fail_count  out  3  current consecutive-denial count.

Behaviour:
- Reset values: state IDLE; validate_code 0; access_code 0; busy 0; locked_out 0; fail_count 0; has_code 0; timer 0.
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.
- IDLE:
  - key_valid loads key_code into access_code and sets has_code; the last digit wins.
  - key_submit with has_code=1 goes to SEND.
  - key_submit with has_code=0 is ignored.
  - key_valid and key_submit in the same cycle: the new digit is loaded and sent.
- SEND:
  - validate_code=1 for exactly one cycle.
  - Next state is WAIT_RESP, timer=0.
  - key inputs are ignored.
- WAIT_RESP:
  - open_access_door=1 goes to OPEN and clears fail_count. This has priority over timeout on the same cycle.
  - Otherwise timer increments.
  - When timer==RESP_TIMEOUT-1 with door still 0, the attempt is denied: fail_count+1.
  - If the new count equals FAIL_LIMIT, go to LOCKOUT; otherwise go to IDLE.
  - has_code clears on either exit.
- OPEN:
  - Hold until open_access_door=0, then go to IDLE.
  - Keys are ignored.
- LOCKOUT:
  - Timer runs 0..LOCKOUT_CYCLES-1.
  - At the end, go to IDLE and clear fail_count.
  - Keys and submit are ignored. A door-open seen here is ignored.
- Expected latency against the lock:
  - submit sampled at edge e0: validate high e0..e1.
  - Lock reaches grant after e2.
  - Door is seen at edge e3, giving OPEN after e3.
- Timer is 8 bits and never wraps: it is cleared on every state entry.
- fail_count saturates at FAIL_LIMIT and cannot exceed it.
- Reset asserted mid-attempt: immediately returns everything to reset values, including fail_count. validate_code drops asynchronously.
- Illegal state encodings go to IDLE on the next clock.

Optional Feature:
- Macro ACCESS_STATS_EN.
- When defined:
  - adds output ports grant_count[7:0] and deny_count[7:0];
  - grant_count increments on each WAIT_RESP->OPEN transition;
  - deny_count increments on each timeout denial;
  - both saturate at 255 and reset to 0.
- When undefined: the ports and registers are absent, and behaviour is otherwise identical.

Decomposition:
- Package access_pkg:
  - state enum with IDLE, SEND, WAIT_RESP, OPEN, LOCKOUT;
  - CODE_W=4;
  - CODE_MIN=4 and CODE_MAX=11 (the lock's grant range, used by the bench);
  - TIMER_W=8.
- One sub-module, cycle_timer:
  - clear, enable and terminal-count compare against a runtime limit;
  - shared by WAIT_RESP and LOCKOUT.

Test Plan:
1. Grant path: key 9, then submit, with the bench lock model attached.
   - Required: validate pulses exactly 1 cycle with access_code=9.
   - Door rises; state is OPEN 3 edges after submit; fail_count=0.
   - After the lock times out the door, return to IDLE; busy falls.
2. Denial: key 2, then submit.
   - Required: no door.
   - Return to IDLE 1+RESP_TIMEOUT cycles after SEND with fail_count=1.
   - access_code=2 stays stable throughout WAIT_RESP.
3. Lockout: three denials with codes 0, 15, 3.
   - Required: after the third, locked_out=1 for exactly 32 cycles.
   - Keys pressed during lockout are ignored.
   - Then fail_count=0 and IDLE.
4. Recovery: two denials, then code 4.
   - Required: grant; fail_count clears to 0.
   - A following denial gives fail_count=1, not 3.
5. Corners:
   - submit with no digit: no validate;
   - key_valid and submit together with key 11: access_code=11 is sent;
   - digits 5 then 7 before submit: 7 is sent.
6. Reset during WAIT_RESP with fail_count=2:
   - Required: all outputs return to reset values with no clock edge.
   - The next attempt starts from fail_count=0.
   - With ACCESS_STATS_EN, counters read 0 after reset.
